// File: rtl/alu_exec_unit_if.sv
// Issue stream and ALU result channel between the RS, the ALU execution unit and the CDB.
// Supplies fallback opcode/width macros when the shared utils.v definitions are absent.
`ifndef OPT_NONE
`define INST_OPT_TP   5:0
`define ROB_IDX_TP    3:0
`define ZERO_ROB_IDX  4'd0
`define OPT_NONE      6'd0
`define OPT_LUI       6'd1
`define OPT_AUIPC     6'd2
`define OPT_JAL       6'd3
`define OPT_JALR      6'd4
`define OPT_BEQ       6'd5
`define OPT_BNE       6'd6
`define OPT_BLT       6'd7
`define OPT_BGE       6'd8
`define OPT_BLTU      6'd9
`define OPT_BGEU      6'd10
`define OPT_ADDI      6'd19
`define OPT_SLTI      6'd20
`define OPT_SLTIU     6'd21
`define OPT_XORI      6'd22
`define OPT_ORI       6'd23
`define OPT_ANDI      6'd24
`define OPT_SLLI      6'd25
`define OPT_SRLI      6'd26
`define OPT_SRAI      6'd27
`define OPT_ADD       6'd28
`define OPT_SUB       6'd29
`define OPT_SLL       6'd30
`define OPT_SLT       6'd31
`define OPT_SLTU      6'd32
`define OPT_XOR       6'd33
`define OPT_SRL       6'd34
`define OPT_SRA       6'd35
`define OPT_OR        6'd36
`define OPT_AND       6'd37
`define OPT_MUL       6'd38
`define OPT_MULH      6'd39
`define OPT_MULHSU    6'd40
`define OPT_MULHU     6'd41
`define OPT_DIV       6'd42
`define OPT_DIVU      6'd43
`define OPT_REM       6'd44
`define OPT_REMU      6'd45
`endif

interface alu_exec_unit_if;
  logic                in_ena;
  logic [`INST_OPT_TP] in_opt;
  logic [31:0]         in_val1;
  logic [31:0]         in_val2;
  logic [31:0]         in_imm;
  logic [`ROB_IDX_TP]  in_rob_idx;
  logic                busy;
  logic                cdb_alu_valid;
  logic [`ROB_IDX_TP]  cdb_alu_src;
  logic [31:0]         cdb_alu_val;

  modport master (
    output in_ena, in_opt, in_val1, in_val2, in_imm, in_rob_idx,
    input  busy, cdb_alu_valid, cdb_alu_src, cdb_alu_val
  );

  modport slave (
    input  in_ena, in_opt, in_val1, in_val2, in_imm, in_rob_idx,
    output busy, cdb_alu_valid, cdb_alu_src, cdb_alu_val
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle RV32I ops plus a 32-step shift-add RV32M multiplier.
// Define ALU_DIV_EN to add a 32-step restoring divider for DIV/DIVU/REM/REMU.
module alu_exec_unit #(
  parameter int MUL_ITER = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           rb,
  alu_exec_unit_if.slave bus
);

  localparam logic [5:0] LAST_ITER = 6'(MUL_ITER - 1);

  // state  | meaning
  // S_IDLE | accepts one issue per cycle; single-cycle ops retire here
  // S_MUL  | shift-add multiply, one partial product per edge, busy high
  // S_DIV  | restoring divide, one quotient bit per edge (ALU_DIV_EN builds)
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_valid, w_valid_nxt;
  logic [`ROB_IDX_TP] r_src, w_src_nxt;
  logic [31:0]        r_val, w_val_nxt;
  logic [`INST_OPT_TP] r_op, w_op_nxt;
  logic [`ROB_IDX_TP] r_rob, w_rob_nxt;
  logic               r_neg, w_neg_nxt;
  logic [5:0]         r_cnt, w_cnt_nxt;
  logic [63:0]        r_mcand, w_mcand_nxt;
  logic [31:0]        r_mplier, w_mplier_nxt;
  logic [63:0]        r_acc, w_acc_nxt;

  logic [31:0] w_v1, w_v2, w_imm;
  logic [31:0] w_alu_res;
  logic        w_alu_hit, w_is_mul;
  logic        w_sgn1, w_sgn2, w_neg;
  logic [31:0] w_mag1, w_mag2;
  logic [63:0] w_acc_step, w_prod;
  logic [31:0] w_mul_res;

  assign w_v1  = bus.in_val1;
  assign w_v2  = bus.in_val2;
  assign w_imm = bus.in_imm;

  always_comb begin
    w_alu_res = '0;
    w_alu_hit = 1'b1;
    w_is_mul  = 1'b0;
    case (bus.in_opt)
      `OPT_LUI:                        w_alu_res = w_imm;
      `OPT_AUIPC, `OPT_JAL, `OPT_JALR: w_alu_res = w_v1 + w_imm;
      `OPT_BEQ:   w_alu_res = {31'b0, w_v1 == w_v2};
      `OPT_BNE:   w_alu_res = {31'b0, w_v1 != w_v2};
      `OPT_BLT:   w_alu_res = {31'b0, $signed(w_v1) < $signed(w_v2)};
      `OPT_BGE:   w_alu_res = {31'b0, $signed(w_v1) >= $signed(w_v2)};
      `OPT_BLTU:  w_alu_res = {31'b0, w_v1 < w_v2};
      `OPT_BGEU:  w_alu_res = {31'b0, w_v1 >= w_v2};
      `OPT_ADDI:  w_alu_res = w_v1 + w_imm;
      `OPT_SLTI:  w_alu_res = {31'b0, $signed(w_v1) < $signed(w_imm)};
      `OPT_SLTIU: w_alu_res = {31'b0, w_v1 < w_imm};
      `OPT_XORI:  w_alu_res = w_v1 ^ w_imm;
      `OPT_ORI:   w_alu_res = w_v1 | w_imm;
      `OPT_ANDI:  w_alu_res = w_v1 & w_imm;
      `OPT_SLLI:  w_alu_res = w_v1 << w_imm[4:0];
      `OPT_SRLI:  w_alu_res = w_v1 >> w_imm[4:0];
      `OPT_SRAI:  w_alu_res = $signed(w_v1) >>> w_imm[4:0];
      `OPT_ADD:   w_alu_res = w_v1 + w_v2;
      `OPT_SUB:   w_alu_res = w_v1 - w_v2;
      `OPT_SLL:   w_alu_res = w_v1 << w_v2[4:0];
      `OPT_SLT:   w_alu_res = {31'b0, $signed(w_v1) < $signed(w_v2)};
      `OPT_SLTU:  w_alu_res = {31'b0, w_v1 < w_v2};
      `OPT_XOR:   w_alu_res = w_v1 ^ w_v2;
      `OPT_SRL:   w_alu_res = w_v1 >> w_v2[4:0];
      `OPT_SRA:   w_alu_res = $signed(w_v1) >>> w_v2[4:0];
      `OPT_OR:    w_alu_res = w_v1 | w_v2;
      `OPT_AND:   w_alu_res = w_v1 & w_v2;
      `OPT_MUL, `OPT_MULH, `OPT_MULHSU, `OPT_MULHU: begin
        w_alu_hit = 1'b0;
        w_is_mul  = 1'b1;
      end
`ifdef ALU_DIV_EN
      `OPT_DIV, `OPT_DIVU, `OPT_REM, `OPT_REMU: w_alu_hit = 1'b0;
`else
      `OPT_DIV, `OPT_DIVU, `OPT_REM, `OPT_REMU: w_alu_res = '0;
`endif
      default: w_alu_hit = 1'b0;
    endcase
  end

  // Engines work on magnitudes; the sign is reapplied to the final value.
  always_comb begin
    w_sgn1 = 1'b0;
    w_sgn2 = 1'b0;
    case (bus.in_opt)
      `OPT_MULH: begin
        w_sgn1 = w_v1[31];
        w_sgn2 = w_v2[31];
      end
      `OPT_MULHSU: w_sgn1 = w_v1[31];
`ifdef ALU_DIV_EN
      `OPT_DIV, `OPT_REM: begin
        w_sgn1 = w_v1[31];
        w_sgn2 = w_v2[31];
      end
`endif
      default: ;
    endcase
    w_mag1 = w_sgn1 ? -w_v1 : w_v1;
    w_mag2 = w_sgn2 ? -w_v2 : w_v2;
    w_neg  = w_sgn1 ^ w_sgn2;
`ifdef ALU_DIV_EN
    if (bus.in_opt == `OPT_REM) w_neg = w_sgn1;
`endif
  end

  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_prod     = r_neg ? -w_acc_step : w_acc_step;
  assign w_mul_res  = (r_op == `OPT_MUL) ? w_prod[31:0] : w_prod[63:32];

`ifdef ALU_DIV_EN
  logic        r_dz, w_dz_nxt;
  logic [31:0] r_dvd, w_dvd_nxt;
  logic [32:0] w_rem_sh, w_rem_sub;
  logic        w_ge;
  logic [31:0] w_quo, w_rem, w_div_res;

  // Divide reuses the multiply registers: r_mcand[31:0] divisor,
  // r_mplier dividend shifting out / quotient shifting in, r_acc[31:0] remainder.
  assign w_rem_sh  = {r_acc[31:0], r_mplier[31]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_mcand[31:0]};
  assign w_ge      = ~w_rem_sub[32];
  assign w_quo     = {r_mplier[30:0], w_ge};
  assign w_rem     = w_ge ? w_rem_sub[31:0] : w_rem_sh[31:0];

  always_comb begin
    if (r_op == `OPT_DIV || r_op == `OPT_DIVU)
      w_div_res = r_dz ? 32'hFFFF_FFFF : (r_neg ? -w_quo : w_quo);
    else
      w_div_res = r_dz ? r_dvd : (r_neg ? -w_rem : w_rem);
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_valid_nxt  = 1'b0;
    w_src_nxt    = r_src;
    w_val_nxt    = r_val;
    w_op_nxt     = r_op;
    w_rob_nxt    = r_rob;
    w_neg_nxt    = r_neg;
    w_cnt_nxt    = r_cnt;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
`ifdef ALU_DIV_EN
    w_dz_nxt     = r_dz;
    w_dvd_nxt    = r_dvd;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.in_ena) begin
          if (w_alu_hit) begin
            w_valid_nxt = 1'b1;
            w_src_nxt   = bus.in_rob_idx;
            w_val_nxt   = w_alu_res;
          end else if (w_is_mul) begin
            w_state_nxt  = S_MUL;
            w_busy_nxt   = 1'b1;
            w_op_nxt     = bus.in_opt;
            w_rob_nxt    = bus.in_rob_idx;
            w_neg_nxt    = w_neg;
            w_cnt_nxt    = '0;
            w_mcand_nxt  = {32'b0, w_mag1};
            w_mplier_nxt = w_mag2;
            w_acc_nxt    = '0;
          end
`ifdef ALU_DIV_EN
          else if (bus.in_opt == `OPT_DIV || bus.in_opt == `OPT_DIVU ||
                   bus.in_opt == `OPT_REM || bus.in_opt == `OPT_REMU) begin
            w_state_nxt  = S_DIV;
            w_busy_nxt   = 1'b1;
            w_op_nxt     = bus.in_opt;
            w_rob_nxt    = bus.in_rob_idx;
            w_neg_nxt    = w_neg;
            w_cnt_nxt    = '0;
            w_mcand_nxt  = {32'b0, w_mag2};
            w_mplier_nxt = w_mag1;
            w_acc_nxt    = '0;
            w_dz_nxt     = (w_v2 == 32'd0);
            w_dvd_nxt    = w_v1;
          end
`endif
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = {r_mcand[62:0], 1'b0};
        w_mplier_nxt = {1'b0, r_mplier[31:1]};
        w_cnt_nxt    = r_cnt + 6'd1;
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
          w_src_nxt   = r_rob;
          w_val_nxt   = w_mul_res;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        w_acc_nxt    = {32'b0, w_rem};
        w_mplier_nxt = w_quo;
        w_cnt_nxt    = r_cnt + 6'd1;
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
          w_src_nxt   = r_rob;
          w_val_nxt   = w_div_res;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || rb) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_src    <= `ZERO_ROB_IDX;
      r_val    <= '0;
      r_op     <= `OPT_NONE;
      r_rob    <= `ZERO_ROB_IDX;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
`ifdef ALU_DIV_EN
      r_dz     <= 1'b0;
      r_dvd    <= '0;
`endif
    end else if (rdy) begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_valid  <= w_valid_nxt;
      r_src    <= w_src_nxt;
      r_val    <= w_val_nxt;
      r_op     <= w_op_nxt;
      r_rob    <= w_rob_nxt;
      r_neg    <= w_neg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
`ifdef ALU_DIV_EN
      r_dz     <= w_dz_nxt;
      r_dvd    <= w_dvd_nxt;
`endif
    end
  end

  assign bus.busy          = r_busy;
  assign bus.cdb_alu_valid = r_valid;
  assign bus.cdb_alu_src   = r_src;
  assign bus.cdb_alu_val   = r_val;

endmodule
